// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone arbiter with bus lock, round-robin and stall watchdog
// Ports:
//   clk, rst (async, active-low)
//   m0_*/m1_*  master-side Wishbone (adr/dat/sel/we/cyc/stb in; dat/ack/err out)
//   s_*        slave-side Wishbone (adr/dat/sel/we/cyc/stb out; dat/ack/err in)
module wb_arb2 #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  input  logic        s_err_i
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [CNT_W-1:0] LP_LIM = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam bit LP_EN = TIMEOUT != 0;
  state_t r_state, w_next;
  logic r_last;
  logic [CNT_W-1:0] r_cnt;
  logic w_own0, w_own1, w_stall, w_fire;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == OWN0 && !m0_cyc_i) r_last <= 1'b0;
      if (r_state == OWN1 && !m1_cyc_i) r_last <= 1'b1;
      r_cnt <= (!w_stall || w_next != r_state || w_fire) ? '0 :
               (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end
  // On a simultaneous request in IDLE the master that did not own the bus last wins.
  always_comb begin
    w_next = r_state;
    w_own0 = r_state == OWN0;
    w_own1 = r_state == OWN1;
    w_next = w_own0 ? (m0_cyc_i ? OWN0 : IDLE) :
             w_own1 ? (m1_cyc_i ? OWN1 : IDLE) :
             (m0_cyc_i && m1_cyc_i) ? (r_last ? OWN0 : OWN1) :
             m0_cyc_i ? OWN0 : m1_cyc_i ? OWN1 : IDLE;
    s_adr_o = w_own1 ? m1_adr_i : w_own0 ? m0_adr_i : '0;
    s_dat_o = w_own1 ? m1_dat_i : w_own0 ? m0_dat_i : '0;
    s_sel_o = w_own1 ? m1_sel_i : w_own0 ? m0_sel_i : '0;
    s_we_o  = (w_own1 & m1_we_i)  | (w_own0 & m0_we_i);
    s_cyc_o = (w_own1 & m1_cyc_i) | (w_own0 & m0_cyc_i);
    s_stb_o = (w_own1 & m1_stb_i) | (w_own0 & m0_stb_i);
  end
  // A stall is a strobe the slave has not terminated; an ack in the firing cycle suppresses the error.
  assign w_stall  = s_stb_o & ~s_ack_i & ~s_err_i;
  assign w_fire   = LP_EN && w_stall && r_cnt == LP_LIM;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & w_own0 & m0_stb_i;
  assign m1_ack_o = s_ack_i & w_own1 & m1_stb_i;
  assign m0_err_o = (s_err_i | w_fire) & w_own0 & m0_stb_i;
  assign m1_err_o = (s_err_i | w_fire) & w_own1 & m1_stb_i;
endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: stalled-strobe cycles before bus error; 0 disables the watchdog.
REQ-002 SHALL have parameter CNT_W, default 8: width of the watchdog counter; TIMEOUT SHALL be < 2^CNT_W.
REQ-003 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mN_adr_i (N=0,1)  in  32  master N address.
REQ-006 SHALL have port mN_dat_i  in  32  master N write data.
REQ-007 SHALL have port mN_dat_o  out  32  master N read data.
REQ-008 SHALL have port mN_sel_i  in  4  master N byte selects.
REQ-009 SHALL have port mN_we_i  in  1  master N write enable.
REQ-010 SHALL have port mN_cyc_i  in  1  master N cycle (bus request and lock).
REQ-011 SHALL have port mN_stb_i  in  1  master N strobe.
REQ-012 SHALL have port mN_ack_o  out  1  master N acknowledge.
REQ-013 SHALL have port mN_err_o  out  1  master N bus error.
REQ-014 SHALL have port s_adr_o / s_dat_o  out  32  slave address / write data.
REQ-015 SHALL have port s_dat_i  in  32  slave read data.
REQ-016 SHALL have port s_sel_o  out  4  slave byte selects.
REQ-017 SHALL have port s_we_o, s_cyc_o, s_stb_o  out  1  slave control.
REQ-018 SHALL have port s_ack_i, s_err_i  in  1  slave termination.

Function
REQ-019 SHALL implement FSM states IDLE, OWN0, OWN1, plus a 1-bit register last (last granted master).
REQ-020 IDLE: one of m0_cyc_i / m1_cyc_i high -> OWN of that master next edge. Both high -> OWN of the master != last. Neither -> stay.
REQ-021 Arbitration latency SHALL be exactly 1 cycle: a request sampled in IDLE yields s_cyc_o in the following cycle.
REQ-022 OWNn SHALL hold while mn_cyc_i=1 (bus lock across any number of strobes). The other master's requests SHALL be ignored.
REQ-023 OWNn with mn_cyc_i=0 -> IDLE next edge, last<=n. The bus SHALL be idle for at least 1 cycle between owners.
REQ-024 In OWNn, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o SHALL combinationally equal master n's inputs.
REQ-025 In IDLE, all s_* outputs SHALL be 0.
REQ-026 m0_dat_o and m1_dat_o SHALL both equal s_dat_i.
REQ-027 mn_ack_o SHALL be s_ack_i & (state==OWNn) & mn_stb_i; the non-owner SHALL see ack=0.
REQ-028 mn_err_o SHALL be (s_err_i | wd_fire) & (state==OWNn) & mn_stb_i.
REQ-029 Watchdog counter cnt SHALL behave as follows:
- clear when s_stb_o=0, s_ack_i=1, s_err_i=1, or state changes;
- otherwise increment by 1;
- saturate at 2^CNT_W-1.
REQ-030 wd_fire SHALL be high in the single cycle where TIMEOUT!=0 and cnt==TIMEOUT-1 with stall continuing; cnt SHALL clear on the next edge.
REQ-031 If wd_fire and s_ack_i coincide, ack SHALL take precedence; err_o SHALL be 0.
REQ-032 A slave ack/err arriving while the state is IDLE or OWN of the other master SHALL be discarded.

Reset
REQ-033 rst=0 SHALL asynchronously force state=IDLE, last=1 (m0 wins first contest), cnt=0. All outputs SHALL then be 0 except mN_dat_o, which follows s_dat_i.
REQ-034 Reset asserted mid-transfer SHALL drop s_cyc_o/s_stb_o within the same cycle, with no ack delivered.
REQ-035 After rst rises, the first grant SHALL occur no earlier than 1 cycle after a request is sampled.

Verification
REQ-036 Reset, then m0_cyc/stb=1 at cycle 0, slave ack at cycle 2 -> s_cyc_o=1 from cycle 1; m0_ack_o=1 at cycle 2 only; m1_ack_o stays 0.
REQ-037 Both masters request at cycle 0 after reset -> OWN0. After m0 drops cyc: IDLE one cycle, then OWN1, s_adr_o = m1_adr_i.
REQ-038 m0 holds cyc across 3 acked strobes (adr 0x20000000, 0x20000004, 0x20000008) while m1 requests throughout -> m1 is not granted until m0_cyc_i=0; then round-robin grants m1.
REQ-039 TIMEOUT=4, slave never acks m1 -> m1_err_o=1 exactly in the 4th stalled cycle, for one cycle. With TIMEOUT=0 there is no err ever.
REQ-040 rst pulsed low during an OWN1 stalled write (s_we_o=1, s_dat_o=0xDEADBEEF) -> all s_* outputs 0 immediately. After release, simultaneous requests grant m0.
REQ-041 s_ack_i=1 in the same cycle wd_fire would occur -> ack delivered, err_o=0, cnt cleared.
